dmem_arbiter: RTL and testbench

- Arbitrates the single-port data memory (9-bit word address, 32-bit data, 1-cycle synchronous read) between the pipeline MEM stage and a DMA/debug loader port.
- The CPU normally has priority and stalls only on a conflict. A starvation counter and a bounded DMA lock give the DMA port guaranteed progress.
- Sits between the MEM stage and the data memory.
- Drives the same wr/rd/addr/wr_data strobes the bench monitors.

---
 rtl/dmem_arb_pkg.sv | 19 +
 rtl/dmem_rd_return.sv | 50 +++++
 rtl/dmem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned DMEM_ADDR_W = 9;
    localparam int unsigned DMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        S_CPU_PRI,
        S_DMA_LOCK,
        S_DMA_COOL
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_DMA
    } owner_e;

endpackage

// File: rtl/dmem_rd_return.sv
// Remembers who issued the read in flight and steers the memory's 1-cycle
// read data to that port; the other port keeps its last returned word.
module dmem_rd_return
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DMEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_rd_grant,
    input  logic              dma_rd_grant,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              cpu_rd_valid,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic              dma_rd_valid,
    output logic [DATA_W-1:0] dma_rd_data
);

    owner_e              owner_q, owner_d;
    logic [DATA_W-1:0]   cpu_data_q, cpu_data_d;
    logic [DATA_W-1:0]   dma_data_q, dma_data_d;

    always_comb begin
        owner_d = OWN_NONE;
        if (cpu_rd_grant)      owner_d = OWN_CPU;
        else if (dma_rd_grant) owner_d = OWN_DMA;

        cpu_rd_valid = (owner_q == OWN_CPU);
        dma_rd_valid = (owner_q == OWN_DMA);
        cpu_rd_data  = cpu_rd_valid ? mem_rd_data : cpu_data_q;
        dma_rd_data  = dma_rd_valid ? mem_rd_data : dma_data_q;
        cpu_data_d   = cpu_rd_data;
        dma_data_d   = dma_rd_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q    <= OWN_NONE;
            cpu_data_q <= '0;
            dma_data_q <= '0;
        end else begin
            owner_q    <= owner_d;
            cpu_data_q <= cpu_data_d;
            dma_data_q <= dma_data_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the MEM stage and a DMA/debug port.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = DMEM_ADDR_W,
    parameter int unsigned DATA_W    = DMEM_DATA_W,
    parameter int unsigned MAX_WAIT  = 4,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic              cpu_stall,
    output logic              cpu_rd_valid,
    output logic [DATA_W-1:0] cpu_rd_data,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic              dma_lock,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wr_data,
    output logic              dma_gnt,
    output logic              dma_rd_valid,
    output logic [DATA_W-1:0] dma_rd_data,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
`ifdef DMEM_ARB_STATS_EN
    output logic [15:0]       stat_conflicts,
    output logic [15:0]       stat_cpu_stalls,
`endif
    input  logic [DATA_W-1:0] mem_rd_data
);

    localparam logic [3:0] WAIT_MAX  = 4'(MAX_WAIT);
    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

    arb_state_e state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic [7:0] burst_q, burst_d;
    logic       cpu_req, conflict, cpu_win, dma_win;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        cpu_req  = cpu_rd | cpu_wr;
        conflict = cpu_req & dma_req;
        cpu_win  = 1'b0;
        dma_win  = 1'b0;
        // Grants are forced off while reset is low so the memory sees no strobe.
        if (reset) begin
            unique case (state_q)
                S_CPU_PRI: begin
                    if (conflict) begin
                        dma_win = (wait_q == WAIT_MAX);
                        cpu_win = (wait_q != WAIT_MAX);
                    end else begin
                        cpu_win = cpu_req;
                        dma_win = dma_req;
                    end
                end
                S_DMA_LOCK: begin
                    dma_win = dma_req;
                    cpu_win = cpu_req & ~dma_req;
                end
                S_DMA_COOL: begin
                    cpu_win = cpu_req;
                    dma_win = dma_req & ~cpu_req;
                end
                default: ;
            endcase
        end

        cpu_stall   = reset & cpu_req & ~cpu_win;
        dma_gnt     = dma_win;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        if (cpu_win) begin
            mem_wr      = cpu_wr;
            mem_rd      = cpu_rd & ~cpu_wr;
            mem_addr    = cpu_addr;
            mem_wr_data = cpu_wr_data;
        end else if (dma_win) begin
            mem_wr      = dma_we;
            mem_rd      = ~dma_we;
            mem_addr    = dma_addr;
            mem_wr_data = dma_wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        unique case (state_q)
            S_CPU_PRI: begin
                if (dma_win && dma_lock) begin
                    burst_d = 8'd1;
                    state_d = (BURST_MAX == 8'd1) ? S_DMA_COOL : S_DMA_LOCK;
                end
            end
            S_DMA_LOCK: begin
                if (dma_win && dma_lock) begin
                    burst_d = burst_q + 8'd1;
                    if (burst_d == BURST_MAX) state_d = S_DMA_COOL;
                end else begin
                    burst_d = '0;
                    state_d = S_CPU_PRI;
                end
            end
            S_DMA_COOL: begin
                burst_d = '0;
                state_d = S_CPU_PRI;
            end
            default: state_d = S_CPU_PRI;
        endcase

        wait_d = '0;
        if (dma_req && !dma_win)
            wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 4'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_CPU_PRI;
            wait_q  <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            burst_q <= burst_d;
        end
    end

    dmem_rd_return #(.DATA_W(DATA_W)) u_rd_return (
        .clk          (clk),
        .reset        (reset),
        .cpu_rd_grant (cpu_win & cpu_rd & ~cpu_wr),
        .dma_rd_grant (dma_win & ~dma_we),
        .mem_rd_data  (mem_rd_data),
        .cpu_rd_valid (cpu_rd_valid),
        .cpu_rd_data  (cpu_rd_data),
        .dma_rd_valid (dma_rd_valid),
        .dma_rd_data  (dma_rd_data)
    );

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] conf_cnt_q, conf_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        conf_cnt_d  = conf_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (conflict && conf_cnt_q != 16'hFFFF)   conf_cnt_d  = conf_cnt_q + 16'd1;
        if (cpu_stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conf_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            conf_cnt_q  <= conf_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stat_conflicts  = conf_cnt_q;
    assign stat_cpu_stalls = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized
// run scored against a cycle-level behavioural model with a shadow memory.
module tb_dmem_arbiter;

    localparam int MAX_WAIT  = 4;
    localparam int MAX_BURST = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_rd, cpu_wr, dma_req, dma_we, dma_lock;
    logic [8:0]  cpu_addr, dma_addr;
    logic [31:0] cpu_wr_data, dma_wr_data;
    logic        cpu_stall, cpu_rd_valid, dma_gnt, dma_rd_valid, mem_rd, mem_wr;
    logic [31:0] cpu_rd_data, dma_rd_data, mem_wr_data;
    logic [8:0]  mem_addr;
    logic [31:0] mem_rd_data = '0;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_conflicts, stat_cpu_stalls;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(9), .DATA_W(32), .MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data),
        .cpu_stall(cpu_stall), .cpu_rd_valid(cpu_rd_valid), .cpu_rd_data(cpu_rd_data),
        .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
        .dma_wr_data(dma_wr_data), .dma_gnt(dma_gnt), .dma_rd_valid(dma_rd_valid),
        .dma_rd_data(dma_rd_data), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data),
`ifdef DMEM_ARB_STATS_EN
        .stat_conflicts(stat_conflicts), .stat_cpu_stalls(stat_cpu_stalls),
`endif
        .mem_rd_data(mem_rd_data)
    );

    // Behavioural single-port RAM with 1-cycle read latency.
    logic [31:0] mem_arr [0:511];
    always @(posedge clk) begin
        if (mem_rd) mem_rd_data <= mem_arr[mem_addr];
        if (mem_wr) mem_arr[mem_addr] = mem_wr_data;
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference model state, expressed in terms of observable behaviour.
    logic [31:0] shadow [0:511];
    int          m_denied, m_beats, m_pend, m_conf, m_stalls;
    bit          m_locked, m_cool;
    logic [31:0] m_pend_data, m_cpu_data, m_dma_data;

    bit          e_cpu_g, e_dma_g, e_stall, e_mem_rd, e_mem_wr, e_cpu_v, e_dma_v;
    logic [8:0]  e_addr;
    logic [31:0] e_wdata, e_cpu_d, e_dma_d;

    task automatic model_reset();
        m_denied = 0; m_beats = 0; m_pend = 0; m_conf = 0; m_stalls = 0;
        m_locked = 0; m_cool = 0;
        m_pend_data = '0; m_cpu_data = '0; m_dma_data = '0;
    endtask

    task automatic set_idle();
        cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wr_data = '0;
        dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = '0; dma_wr_data = '0;
    endtask

    task automatic preload(input logic [8:0] a, input logic [31:0] d);
        mem_arr[a] = d;
        shadow[a]  = d;
    endtask

    // Expected outputs for the current inputs and model state.
    task automatic predict();
        bit creq;
        bit dma_first;
        creq      = cpu_rd | cpu_wr;
        dma_first = m_cool ? 1'b0 : (m_locked ? 1'b1 : (m_denied >= MAX_WAIT));
        if (creq && dma_req) begin
            e_dma_g = dma_first;
            e_cpu_g = !dma_first;
        end else begin
            e_cpu_g = creq;
            e_dma_g = dma_req;
        end
        e_stall = creq && !e_cpu_g;
        e_mem_rd = 0; e_mem_wr = 0; e_addr = '0; e_wdata = '0;
        if (e_cpu_g) begin
            e_mem_wr = cpu_wr; e_mem_rd = cpu_rd && !cpu_wr; e_addr = cpu_addr; e_wdata = cpu_wr_data;
        end else if (e_dma_g) begin
            e_mem_wr = dma_we; e_mem_rd = !dma_we; e_addr = dma_addr; e_wdata = dma_wr_data;
        end
        e_cpu_v = (m_pend == 1);
        e_dma_v = (m_pend == 2);
        e_cpu_d = e_cpu_v ? m_pend_data : m_cpu_data;
        e_dma_d = e_dma_v ? m_pend_data : m_dma_data;
    endtask

    // Moves to the next cycle and updates the model with what was granted.
    task automatic advance();
        @(posedge clk);
        if (m_pend == 1) m_cpu_data = m_pend_data;
        if (m_pend == 2) m_dma_data = m_pend_data;
        m_pend = 0;
        if (e_cpu_g && cpu_wr)       shadow[cpu_addr] = cpu_wr_data;
        else if (e_cpu_g)            begin m_pend = 1; m_pend_data = shadow[cpu_addr]; end
        else if (e_dma_g && dma_we)  shadow[dma_addr] = dma_wr_data;
        else if (e_dma_g)            begin m_pend = 2; m_pend_data = shadow[dma_addr]; end
        if (dma_req && !e_dma_g) m_denied = (m_denied < MAX_WAIT) ? m_denied + 1 : MAX_WAIT;
        else                     m_denied = 0;
        if (m_cool) begin
            m_cool = 0; m_locked = 0; m_beats = 0;
        end else if (e_dma_g && dma_lock) begin
            m_beats++;
            if (m_beats >= MAX_BURST) begin m_cool = 1; m_locked = 0; m_beats = 0; end
            else m_locked = 1;
        end else begin
            m_locked = 0; m_beats = 0;
        end
        if ((cpu_rd | cpu_wr) && dma_req && m_conf < 65535) m_conf++;
        if (e_stall && m_stalls < 65535) m_stalls++;
        #1;
    endtask

    task automatic idle_cycles(input int n);
        set_idle();
        for (int i = 0; i < n; i++) begin
            predict();
            advance();
        end
    endtask

    task automatic test_reset();
        reset = 0;
        set_idle();
        cpu_rd = 1; cpu_addr = 9'd3; dma_req = 1; dma_addr = 9'd4; dma_wr_data = 32'h1234;
        #1;
        n_vec++;
        if ({mem_rd, mem_wr, cpu_stall, dma_gnt, cpu_rd_valid, dma_rd_valid} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_strobes: got %b expected 000000",
                     {mem_rd, mem_wr, cpu_stall, dma_gnt, cpu_rd_valid, dma_rd_valid});
        end
        n_vec++;
        if (mem_addr !== 9'd0 || mem_wr_data !== 32'd0) begin
            n_err++;
            $display("FAIL reset_mem_bus: got addr %h data %h expected 0/0", mem_addr, mem_wr_data);
        end
        n_vec++;
        if (cpu_rd_data !== 32'd0 || dma_rd_data !== 32'd0) begin
            n_err++;
            $display("FAIL reset_rd_data: got cpu %h dma %h expected 0/0", cpu_rd_data, dma_rd_data);
        end
        @(posedge clk); #1;
        set_idle();
        reset = 1;
        model_reset();
        idle_cycles(1);
    endtask

    task automatic test_cpu_read();
        idle_cycles(2);
        preload(9'd5, 32'hDEADBEEF);
        cpu_rd = 1; cpu_addr = 9'd5;
        predict();
        @(negedge clk);
        n_vec++;
        if ({cpu_stall, mem_rd, mem_wr} !== 3'b010 || mem_addr !== 9'd5) begin
            n_err++;
            $display("FAIL cpu_read_issue: got stall/rd/wr %b addr %0d expected 010 addr 5",
                     {cpu_stall, mem_rd, mem_wr}, mem_addr);
        end
        advance();
        set_idle();
        predict();
        @(negedge clk);
        n_vec++;
        if (cpu_rd_valid !== 1'b1 || cpu_rd_data !== 32'hDEADBEEF || dma_rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL cpu_read_return: got valid %b data %h dma_valid %b expected 1 DEADBEEF 0",
                     cpu_rd_valid, cpu_rd_data, dma_rd_valid);
        end
        advance();
    endtask

    task automatic test_rd_wr_both();
        idle_cycles(2);
        cpu_rd = 1; cpu_wr = 1; cpu_addr = 9'd7; cpu_wr_data = 32'hA5A5A5A5;
        predict();
        @(negedge clk);
        n_vec++;
        if ({mem_wr, mem_rd} !== 2'b10 || mem_addr !== 9'd7 || mem_wr_data !== 32'hA5A5A5A5) begin
            n_err++;
            $display("FAIL rdwr_as_write: got wr/rd %b addr %0d data %h expected 10 7 A5A5A5A5",
                     {mem_wr, mem_rd}, mem_addr, mem_wr_data);
        end
        advance();
        set_idle();
        predict();
        @(negedge clk);
        n_vec++;
        if (cpu_rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rdwr_no_valid: got cpu_rd_valid %b expected 0", cpu_rd_valid);
        end
        advance();
        cpu_rd = 1; cpu_addr = 9'd7;
        predict();
        advance();
        set_idle();
        predict();
        @(negedge clk);
        n_vec++;
        if (cpu_rd_valid !== 1'b1 || cpu_rd_data !== 32'hA5A5A5A5) begin
            n_err++;
            $display("FAIL rdwr_readback: got valid %b data %h expected 1 A5A5A5A5", cpu_rd_valid, cpu_rd_data);
        end
        advance();
    endtask

    task automatic test_alternating();
        idle_cycles(2);
        preload(9'd1, 32'h11);
        preload(9'd2, 32'h22);
        cpu_rd = 1; cpu_addr = 9'd1;
        predict();
        advance();
        set_idle();
        dma_req = 1; dma_we = 0; dma_addr = 9'd2;
        predict();
        @(negedge clk);
        n_vec++;
        if (cpu_rd_valid !== 1'b1 || cpu_rd_data !== 32'h11 || dma_rd_valid !== 1'b0 || dma_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL alt_cpu_return: got cv %b cd %h dv %b gnt %b expected 1 11 0 1",
                     cpu_rd_valid, cpu_rd_data, dma_rd_valid, dma_gnt);
        end
        advance();
        set_idle();
        predict();
        @(negedge clk);
        n_vec++;
        if (dma_rd_valid !== 1'b1 || dma_rd_data !== 32'h22 || cpu_rd_valid !== 1'b0 || cpu_rd_data !== 32'h11) begin
            n_err++;
            $display("FAIL alt_dma_return: got dv %b dd %h cv %b cd %h expected 1 22 0 11",
                     dma_rd_valid, dma_rd_data, cpu_rd_valid, cpu_rd_data);
        end
        advance();
    endtask

    task automatic test_starvation();
        idle_cycles(3);
        for (int i = 0; i < 15; i++) begin
            cpu_wr = 1; cpu_rd = 0; cpu_addr = 9'($urandom_range(16, 31)); cpu_wr_data = $urandom();
            dma_req = 1; dma_we = 0; dma_lock = 0; dma_addr = 9'($urandom_range(0, 15));
            predict();
            @(negedge clk);
            n_vec++;
            if (dma_gnt !== ((i % 5) == 4) || cpu_stall !== ((i % 5) == 4)) begin
                n_err++;
                $display("FAIL starve_cycle%0d: got gnt %b stall %b expected %b %b",
                         i, dma_gnt, cpu_stall, (i % 5) == 4, (i % 5) == 4);
            end
            advance();
        end
        idle_cycles(1);
    endtask

    task automatic test_burst();
        bit want;
        idle_cycles(3);
        for (int i = 0; i < 17; i++) begin
            cpu_wr = 1; cpu_rd = 0; cpu_addr = 9'($urandom_range(16, 31)); cpu_wr_data = $urandom();
            dma_req = 1; dma_we = 1; dma_lock = 1; dma_addr = 9'($urandom_range(32, 47));
            dma_wr_data = $urandom();
            // 4 denied, 8 locked beats, 1 cool cycle, 3 more denied, then DMA again.
            want = (i >= 4 && i <= 11) || i == 16;
            predict();
            @(negedge clk);
            n_vec++;
            if (dma_gnt !== want || cpu_stall !== want) begin
                n_err++;
                $display("FAIL burst_cycle%0d: got gnt %b stall %b expected %b %b",
                         i, dma_gnt, cpu_stall, want, want);
            end
            advance();
        end
        idle_cycles(2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            cpu_rd      = ($urandom_range(0, 99) < 45);
            cpu_wr      = ($urandom_range(0, 99) < 35);
            cpu_addr    = 9'($urandom_range(0, 15));
            cpu_wr_data = $urandom();
            dma_req     = ($urandom_range(0, 99) < 65);
            dma_we      = 1'($urandom_range(0, 1));
            dma_lock    = ($urandom_range(0, 99) < 70);
            dma_addr    = 9'($urandom_range(0, 15));
            dma_wr_data = $urandom();
            predict();
            @(negedge clk);
            n_vec++;
            if ({cpu_stall, dma_gnt, mem_rd, mem_wr, cpu_rd_valid, dma_rd_valid} !==
                {e_stall, e_dma_g, e_mem_rd, e_mem_wr, e_cpu_v, e_dma_v}) begin
                n_err++;
                $display("FAIL rand_ctrl cycle %0d: got %b expected %b", i,
                         {cpu_stall, dma_gnt, mem_rd, mem_wr, cpu_rd_valid, dma_rd_valid},
                         {e_stall, e_dma_g, e_mem_rd, e_mem_wr, e_cpu_v, e_dma_v});
            end
            n_vec++;
            if (mem_addr !== e_addr || mem_wr_data !== e_wdata) begin
                n_err++;
                $display("FAIL rand_mem_bus cycle %0d: got %h/%h expected %h/%h",
                         i, mem_addr, mem_wr_data, e_addr, e_wdata);
            end
            n_vec++;
            if (cpu_rd_data !== e_cpu_d || dma_rd_data !== e_dma_d) begin
                n_err++;
                $display("FAIL rand_rd_data cycle %0d: got %h/%h expected %h/%h",
                         i, cpu_rd_data, dma_rd_data, e_cpu_d, e_dma_d);
            end
            advance();
        end
        idle_cycles(2);
`ifdef DMEM_ARB_STATS_EN
        n_vec++;
        if (int'(stat_conflicts) != m_conf || int'(stat_cpu_stalls) != m_stalls) begin
            n_err++;
            $display("FAIL stats: got %0d/%0d expected %0d/%0d",
                     stat_conflicts, stat_cpu_stalls, m_conf, m_stalls);
        end
`endif
    endtask

    task automatic test_reset_mid_read();
        idle_cycles(2);
        preload(9'd9, 32'hCAFEF00D);
        cpu_rd = 1; cpu_addr = 9'd9;
        predict();
        advance();
        reset = 0;
        dma_req = 1; dma_addr = 9'd9;
        #1;
        n_vec++;
        if ({mem_rd, mem_wr, cpu_stall, dma_gnt, cpu_rd_valid, dma_rd_valid} !== 6'b0 ||
            mem_addr !== 9'd0 || cpu_rd_data !== 32'd0 || dma_rd_data !== 32'd0) begin
            n_err++;
            $display("FAIL midread_reset: got strobes %b addr %h cd %h dd %h expected all 0",
                     {mem_rd, mem_wr, cpu_stall, dma_gnt, cpu_rd_valid, dma_rd_valid},
                     mem_addr, cpu_rd_data, dma_rd_data);
        end
        repeat (2) @(posedge clk);
        #1;
        set_idle();
        reset = 1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (cpu_rd_valid !== 1'b0 || dma_rd_valid !== 1'b0 || cpu_rd_data !== 32'd0) begin
                n_err++;
                $display("FAIL post_reset_valid%0d: got cv %b dv %b cd %h expected 0 0 0",
                         i, cpu_rd_valid, dma_rd_valid, cpu_rd_data);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 0;
        set_idle();
        for (int i = 0; i < 512; i++) preload(9'(i), $urandom());
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_cpu_read();
        test_rd_wr_both();
        test_alternating();
        test_starvation();
        test_burst();
        test_random();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
